// File: rtl/alarm_code_sender_if.sv
// rtl/alarm_code_sender_if.sv - code/strobe/response signal bundle between controller and alarm_code_sender
interface alarm_code_sender_if #(
  parameter int CODE_W = 4
);
  logic              start;
  logic [CODE_W-1:0] code;
  logic              Y;
  logic              in;
  logic              s;
  logic              busy;
  logic              done;
  logic              match;

  modport master (
    output start, code, Y,
    input  in, s, busy, done, match
  );

  modport slave (
    input  start, code, Y,
    output in, s, busy, done, match
  );
endinterface

// File: rtl/alarm_code_sender.sv
// rtl/alarm_code_sender.sv - serial code sender with strobe timing and unlock-response wait
// Optional macro ALARM_SENDER_PARITY_EN appends an even-parity bit after the code bits.
module alarm_code_sender #(
  parameter int CODE_W    = 4,
  parameter int STROBE_HI = 2,
  parameter int GAP       = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  alarm_code_sender_if.slave bus
);

`ifdef ALARM_SENDER_PARITY_EN
  localparam int NBITS = CODE_W + 1;
`else
  localparam int NBITS = CODE_W;
`endif

  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int STR_W = $clog2(STROBE_HI + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_WAIT_Y,
    S_FIN
  } state_t;

  state_t            state;
  logic [NBITS-1:0]  frame;
  logic [NBITS-1:0]  frame_load;
  logic [NBITS-1:0]  frame_nx;
  logic [BIT_W-1:0]  bit_cnt;
  logic [STR_W-1:0]  str_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;

`ifdef ALARM_SENDER_PARITY_EN
  assign frame_load = {bus.code, ^bus.code};
`else
  assign frame_load = bus.code;
`endif

  // Current bit always sits in the frame MSB; shifting exposes the next one.
  assign frame_nx = frame << 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      str_cnt   <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      bus.in    <= 1'b0;
      bus.s     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.match <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            frame     <= frame_load;
            bit_cnt   <= '0;
            bus.in    <= frame_load[NBITS-1];
            bus.s     <= 1'b0;
            bus.busy  <= 1'b1;
            bus.match <= 1'b0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          bus.s   <= 1'b1;
          str_cnt <= STR_W'(1);
          state   <= S_STROBE;
        end
        S_STROBE: begin
          if (str_cnt == STR_W'(STROBE_HI)) begin
            bus.s   <= 1'b0;
            gap_cnt <= GAP_W'(1);
            state   <= S_GAP;
          end else begin
            str_cnt <= str_cnt + STR_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP)) begin
            if (bit_cnt == BIT_W'(NBITS - 1)) begin
              bus.in <= 1'b0;
              to_cnt <= TO_W'(1);
              state  <= S_WAIT_Y;
            end else begin
              frame   <= frame_nx;
              bus.in  <= frame_nx[NBITS-1];
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= S_SETUP;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_WAIT_Y: begin
          // Y is checked before the timeout so a response on the final cycle still counts.
          if (bus.Y) begin
            bus.match <= 1'b1;
            bus.done  <= 1'b1;
            state     <= S_FIN;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            bus.match <= 1'b0;
            bus.done  <= 1'b1;
            state     <= S_FIN;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_FIN: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_code_sender.sv
// tb/tb_alarm_code_sender.sv - scoreboard bench for alarm_code_sender timing, result and reset behaviour
module tb_alarm_code_sender;
  localparam int CODE_W = 4;
  localparam int SH     = 2;
  localparam int G      = 2;
  localparam int TO     = 8;
  localparam int P      = 1 + SH + G;
`ifdef ALARM_SENDER_PARITY_EN
  localparam int NB = CODE_W + 1;
`else
  localparam int NB = CODE_W;
`endif
  localparam int W = NB * P + 1;

  logic clk;
  logic rst;
  alarm_code_sender_if #(.CODE_W(CODE_W)) bus ();

  alarm_code_sender #(
    .CODE_W(CODE_W), .STROBE_HI(SH), .GAP(G), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_seen = 0;
  logic bitq[$];
  logic matchq[$];
  logic s_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_bit(input logic [CODE_W-1:0] c, input int k);
    if (k < CODE_W) return c[CODE_W-1-k];
    return ^c;
  endfunction

  // Scoreboard side: each rising strobe consumes one bit, each done consumes one result.
  always @(negedge clk) begin
    if (bus.s && !s_q) begin
      if (bitq.size() == 0) check("sb_bit_underflow", 1, 0);
      else check("sb_bit", bus.in, bitq.pop_front());
    end
    if (bus.done) begin
      done_seen++;
      if (matchq.size() == 0) check("sb_match_underflow", 1, 0);
      else check("sb_match", bus.match, matchq.pop_front());
    end
    s_q = bus.s;
  end

  // Caller is at a negedge; start is accepted at the next posedge (edge 0).
  task automatic run_txn(input logic [CODE_W-1:0] c, input int ycyc, input int junk, input bit hold);
    int   fin;
    logic m;
    logic es, ei;
    if (ycyc >= W && ycyc < W + TO) begin fin = ycyc + 1; m = 1'b1; end
    else begin fin = W + TO; m = 1'b0; end
    for (int k = 0; k < NB; k++) bitq.push_back(exp_bit(c, k));
    matchq.push_back(m);
    bus.start = 1'b1;
    bus.code  = c;
    @(posedge clk);
    for (int cy = 1; cy <= fin + 1; cy++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.Y     = 1'b0;
      if (cy == 1) bus.code = ~c;
      if (cy <= NB * P) begin
        es = ((cy - 1) % P >= 1) && ((cy - 1) % P <= SH);
        ei = exp_bit(c, (cy - 1) / P);
      end else begin
        es = 1'b0;
        ei = 1'b0;
      end
      check("s", bus.s, es);
      check("in", bus.in, ei);
      check("busy", bus.busy, cy <= fin);
      check("done", bus.done, cy == fin);
      check("match", bus.match, (cy >= fin) ? m : 1'b0);
      if (cy == junk) begin
        bus.start = 1'b1;
        bus.code  = '1;
        bus.Y     = 1'b1;
      end
      if (cy == ycyc) bus.Y = 1'b1;
      if (cy == fin && hold) bus.start = 1'b1;
    end
    bus.start = 1'b0;
    bus.Y     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic reset_mid_txn(input logic [CODE_W-1:0] c);
    int d0;
    for (int k = 0; k < NB; k++) bitq.push_back(exp_bit(c, k));
    matchq.push_back(1'b0);
    bus.start = 1'b1;
    bus.code  = c;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_seen;
    for (int cy = 2; cy <= 9; cy++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in", bus.in, 0);
    check("rst_s", bus.s, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_match", bus.match, 0);
    check("rst_bits_sent", bitq.size(), NB - 2);
    bitq.delete();
    matchq.delete();
    rst = 1'b1;
    idle(1);
    check("rst_no_done", done_seen, d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.code  = '0;
    bus.Y     = 1'b0;
    idle(2);
    check("reset_in", bus.in, 0);
    check("reset_s", bus.s, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_match", bus.match, 0);
    rst = 1'b1;

    run_txn(4'b0101, 23, 0, 1'b0);
    idle(3);
    check("match_held", bus.match, 1);
    check("idle_busy", bus.busy, 0);
    run_txn(4'b0101, 0, 10, 1'b0);
    idle(1);
    run_txn(4'b1010, W, 0, 1'b1);
    run_txn(4'b0110, W + TO - 1, 0, 1'b0);
    idle(2);
    reset_mid_txn(4'b0101);
    run_txn(4'b0111, 0, 0, 1'b0);
    idle(1);
    run_txn(4'b0011, W + 4, 5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      run_txn(CODE_W'($urandom), $urandom_range(W + TO + 2, 0), 0, 1'b0);
    end
    idle(2);
    check("sb_bits_drained", bitq.size(), 0);
    check("sb_match_drained", matchq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
